// File: rtl/mac_pkg.sv
// Shared field widths and the request record used by the read arbiter and memory_access_controller.
// Effective arbitration priority is one bit wider than QoS so an aged port can outrank QoS 15.
package mac_pkg;
  localparam int MAC_ADDR_W = 32;
  localparam int MAC_TAG_W  = 4;
  localparam int MAC_ID_W   = 3;
  localparam int MAC_LEN_W  = 2;
  localparam int MAC_QOS_W  = 4;
  localparam int MAC_PRIO_W = MAC_QOS_W + 1;

  typedef struct packed {
    logic [MAC_ADDR_W-1:0] addr;
    logic [MAC_TAG_W-1:0]  tag;
    logic [MAC_ID_W-1:0]   id;
    logic [MAC_LEN_W-1:0]  len;
    logic [MAC_QOS_W-1:0]  qos;
  } mac_req_t;
endpackage

// File: rtl/mac_rr_pick.sv
// One-hot winner among valid ports: highest priority, ties broken upward from iRrPtr+1.
// Purely combinational, no backpressure of its own.
module mac_rr_pick
  import mac_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = MAC_PRIO_W
) (
  input  logic [N-1:0]        iValid,
  input  logic [N*PW-1:0]     iPrio,
  input  logic [MAC_ID_W-1:0] iRrPtr,
  output logic [N-1:0]        oGrant
);
  logic [PW-1:0] maxPrio;
  logic [N-1:0]  cand;
  logic          found;
  int            idx;

  always_comb begin
    maxPrio = '0;
    cand    = '0;
    oGrant  = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++)
      if (iValid[i] && (iPrio[i*PW +: PW] > maxPrio)) maxPrio = iPrio[i*PW +: PW];
    for (int i = 0; i < N; i++)
      cand[i] = iValid[i] && (iPrio[i*PW +: PW] == maxPrio);
    // Walk N slots starting just after the last winner, wrapping once.
    for (int k = 1; k <= N; k++) begin
      idx = int'(iRrPtr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx]) begin
        oGrant[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_rd_arbiter.sv
// QoS/round-robin read-request arbiter feeding the MAC; MAC_ARB_AGING_EN adds starvation aging.
// Latency 1 cycle (registered output stage), one request per cycle sustained.
// Backpressure: iMAC_ReadyRd low with the stage full forces every oArb_ReadyRd low.
module mac_rd_arbiter
  import mac_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                           iClk,
  input  logic                           iReset_n,
  input  logic [NUM_PORTS-1:0]           iArb_ValidRd,
  input  logic [MAC_ADDR_W*NUM_PORTS-1:0] iArb_AddrRd,
  input  logic [MAC_TAG_W*NUM_PORTS-1:0] iArb_TagRd,
  input  logic [MAC_LEN_W*NUM_PORTS-1:0] iArb_LenRd,
  input  logic [MAC_QOS_W*NUM_PORTS-1:0] iArb_QoSRd,
  output logic [NUM_PORTS-1:0]           oArb_ReadyRd,
  output logic                           oMAC_ValidRd,
  output logic [MAC_ADDR_W-1:0]          oMAC_AddrRd,
  output logic [MAC_TAG_W-1:0]           oMAC_TagRd,
  output logic [MAC_ID_W-1:0]            oMAC_IdRd,
  output logic [MAC_LEN_W-1:0]           oMAC_LenRd,
  output logic [MAC_QOS_W-1:0]           oMAC_QoSRd,
  input  logic                           iMAC_ReadyRd
);
  logic                            outVld;
  mac_req_t                        outReq;
  logic [MAC_ID_W-1:0]             rrPtr;
  logic                            canLoad;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS*MAC_PRIO_W-1:0] effPrio;
  logic [MAC_ID_W-1:0]             winIdx;
  mac_req_t                        winReq;

`ifdef MAC_ARB_AGING_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] waitCnt [NUM_PORTS];

  always_ff @(posedge iClk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!iReset_n || !iArb_ValidRd[i] || oArb_ReadyRd[i]) waitCnt[i] <= '0;
      else if (waitCnt[i] != CNT_W'(STARVE_LIMIT)) waitCnt[i] <= waitCnt[i] + CNT_W'(1);
    end
  end

  // A saturated counter lifts the port above every un-aged QoS value.
  always_comb begin
    effPrio = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      effPrio[i*MAC_PRIO_W +: MAC_PRIO_W] = (waitCnt[i] == CNT_W'(STARVE_LIMIT)) ?
        MAC_PRIO_W'(16) : {1'b0, iArb_QoSRd[i*MAC_QOS_W +: MAC_QOS_W]};
  end
`else
  always_comb begin
    effPrio = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      effPrio[i*MAC_PRIO_W +: MAC_PRIO_W] = {1'b0, iArb_QoSRd[i*MAC_QOS_W +: MAC_QOS_W]};
  end
`endif

  mac_rr_pick #(.N(NUM_PORTS), .PW(MAC_PRIO_W)) uPick (
    .iValid (iArb_ValidRd),
    .iPrio  (effPrio),
    .iRrPtr (rrPtr),
    .oGrant (grant)
  );

  assign canLoad      = !outVld || iMAC_ReadyRd;
  assign oArb_ReadyRd = (iReset_n && canLoad) ? grant : '0;

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) winIdx = MAC_ID_W'(i);
    winReq.addr = iArb_AddrRd[int'(winIdx)*MAC_ADDR_W +: MAC_ADDR_W];
    winReq.tag  = iArb_TagRd[int'(winIdx)*MAC_TAG_W +: MAC_TAG_W];
    winReq.id   = winIdx;
    winReq.len  = iArb_LenRd[int'(winIdx)*MAC_LEN_W +: MAC_LEN_W];
    winReq.qos  = iArb_QoSRd[int'(winIdx)*MAC_QOS_W +: MAC_QOS_W];
  end

  // Reset drops any held request; the client already saw its handshake, so there is no replay.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      outVld <= 1'b0;
      outReq <= '0;
      rrPtr  <= MAC_ID_W'(NUM_PORTS - 1);
    end else if (canLoad) begin
      if (|grant) begin
        outVld <= 1'b1;
        outReq <= winReq;
        rrPtr  <= winIdx;
      end else begin
        outVld <= 1'b0;
      end
    end
  end

  assign oMAC_ValidRd = outVld;
  assign oMAC_AddrRd  = outReq.addr;
  assign oMAC_TagRd   = outReq.tag;
  assign oMAC_IdRd    = outReq.id;
  assign oMAC_LenRd   = outReq.len;
  assign oMAC_QoSRd   = outReq.qos;
endmodule

// File: doc/mac_rd_arbiter.md
# mac_rd_arbiter

Read-request arbiter directly upstream of `memory_access_controller`: collects read requests from `NUM_PORTS` client ports and forwards one request at a time into the MAC read-request channel (`iMAC_ValidRd`/`oMAC_ReadyRd` on the MAC side). Selection uses QoS priority with round-robin tie-break and optional starvation aging. A one-entry registered output stage holds each request until the MAC accepts it and sustains one request per cycle.

## Interface
- `NUM_PORTS`, 4: client read ports; legal range 2..8, because the port index is carried on the 3-bit Id.
- `STARVE_LIMIT`, 15: wait cycles before a pending port is promoted; used only with aging; legal range ≥1.
- `iClk`  in  1  clock.
- `iReset_n`  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `iArb_ValidRd`  in  NUM_PORTS  per-port request valid.
- `iArb_AddrRd`  in  32*NUM_PORTS  per-port address, port i at [32i+31:32i].
- `iArb_TagRd`  in  4*NUM_PORTS  per-port tag.
- `iArb_LenRd`  in  2*NUM_PORTS  per-port burst length code.
- `iArb_QoSRd`  in  4*NUM_PORTS  per-port QoS, higher value = more urgent.
- `oArb_ReadyRd`  out  NUM_PORTS  per-port accept; one-hot or zero.
- `oMAC_ValidRd`  out  1  request valid to MAC.
- `oMAC_AddrRd`  out  32  address.
- `oMAC_TagRd`  out  4  tag.
- `oMAC_IdRd`  out  3  winning port index, zero-extended.
- `oMAC_LenRd`  out  2  length code.
- `oMAC_QoSRd`  out  4  original (unpromoted) QoS.
- `iMAC_ReadyRd`  in  1  MAC accept.

## Operation
- Output stage states:
  - EMPTY: `oMAC_ValidRd`=0.
  - FULL: `oMAC_ValidRd`=1; fields held stable.
- `can_load` = EMPTY, or (FULL and `iMAC_ReadyRd`).
- When `can_load` and any `iArb_ValidRd` is high, the arbiter picks winner w and drives `oArb_ReadyRd[w]`=1 in the same cycle (combinational from valids, QoS, counters and pointer).
- On the next edge, port w's fields load into the output stage with `oMAC_IdRd`=w, and the state becomes or stays FULL.
- When `can_load` holds but no port is valid, a MAC accept moves FULL to EMPTY.
- When `can_load`=0, all `oArb_ReadyRd` are 0.
- Effective priority is 5 bits: {0,QoS}. With aging, a port whose wait counter equals `STARVE_LIMIT` gets 16.
- The highest effective priority wins. Ties resolve round-robin, searching upward from `rr_ptr+1` modulo `NUM_PORTS`. `rr_ptr` becomes w on every grant.
- Clients must hold valid and fields stable until their ready is seen; a client dropping valid before grant is legal, and the port is simply not considered.
- Reset values:
  - `oMAC_ValidRd`=0 and all `oMAC_*` fields 0.
  - `oArb_ReadyRd`=0 while `iReset_n`=0.
  - `rr_ptr`=NUM_PORTS-1, so port 0 wins the first tie.
  - Wait counters 0.
- Reset asserted mid-transfer discards the held request; no replay.

## Timing
- Latency is 1 cycle from client handshake to `oMAC_ValidRd`.
- Throughput is 1 request/cycle while `iMAC_ReadyRd`=1.
- `oMAC_*` are registered outputs. `oArb_ReadyRd` is combinational, and `iMAC_ReadyRd` feeds it combinationally.
- A grant and a MAC accept in the same cycle are a back-to-back load; there is no bubble.

## Configuration
- `MAC_ARB_AGING_EN` defined:
  - Per-port wait counter of width $clog2(STARVE_LIMIT+1).
  - Increments each cycle the port is valid and not granted, saturating at `STARVE_LIMIT`.
  - Clears on grant or when valid is low.
  - Saturated ports get priority 16; ties among promoted ports use round-robin.
- Undefined: no counters; pure QoS + round-robin; a low-QoS port can starve indefinitely.

## Structure
- `mac_pkg`: `MAC_ADDR_W`=32, `MAC_TAG_W`=4, `MAC_ID_W`=3, `MAC_LEN_W`=2, `MAC_QOS_W`=4, and a request struct typedef (addr/tag/id/len/qos). This package is shared with `memory_access_controller`.
- Sub-module `mac_rr_pick`: given priority vectors and `rr_ptr`, returns a one-hot winner. It is purely combinational and reusable for the write-side arbiter.

## Test plan
- Single request: port 2 valid, QoS 3, addr 0x1000, `iMAC_ReadyRd`=1 → `oArb_ReadyRd`=0b0100 in cycle 0; next cycle `oMAC_ValidRd`=1, IdRd=2, AddrRd=0x1000, QoSRd=3.
- QoS win: ports 0/1/3 valid with QoS 1/9/4 → port 1 granted first, then port 3, then port 0.
- Tie round-robin: all 4 ports valid with QoS 5, MAC always ready → grant order 0,1,2,3,0; one `oMAC_ValidRd` per cycle with no bubbles.
- Backpressure: `iMAC_ReadyRd`=0 for 5 cycles with FULL → `oMAC_*` stable, all `oArb_ReadyRd`=0; on ready=1, an immediate next grant the same cycle.
- Aging (macro on, `STARVE_LIMIT`=3): port 0 QoS 15 continuous, port 1 QoS 0, MAC always ready → port 1 granted on the 4th cycle after it asserts valid. With the macro off, port 1 is never granted.
- Reset mid-operation: `iReset_n`=0 while FULL → next cycle `oMAC_ValidRd`=0; after release, a tie between ports 0 and 3 grants port 0.
